// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand forwarding and hazard control for a five-stage pipeline.
//   Resolves execute-stage operands from EXE_MEM, MEM_WB or a one-entry
//   hold buffer. Inserts a one-cycle bubble on load-use hazards. Freezes
//   the pipeline while the data memory is busy, and latches a timeout
//   error if the memory never answers.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   IF_ID_rs1/rs2                  decode-stage source registers
//   ID_EXE_*                       execute-stage operands and controls
//   EXE_MEM_*                      memory-stage write-back candidate and access
//   mem_ready                      data memory completes this cycle
//   MEM_WB_*, WB_wt_data           write-back stage result
//   forwarding_*_out               resolved ALU operands and store data
//   stall_pc, stall_IF_ID          hold the front of the pipeline
//   flush_ID_EXE                   insert a bubble into execute
//   stall_all                      freeze the whole pipeline (memory busy)
//   mem_timeout                    sticky error flag; only reset clears it
//
// state    | meaning
// ---------+----------------------------------------------------
// RUN      | normal flow, no outstanding memory wait
// MEM_WAIT | memory access outstanding, counting wait cycles
// ERROR    | memory timed out, pipeline frozen until reset

module fwd_hazard_unit #(
  parameter int XLEN        = 32,
  parameter int RW          = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   IF_ID_rs1,
  input  logic [RW-1:0]   IF_ID_rs2,
  input  logic [RW-1:0]   ID_EXE_read_reg1,
  input  logic [RW-1:0]   ID_EXE_read_reg2,
  input  logic [XLEN-1:0] ID_EXE_ALU_A,
  input  logic [XLEN-1:0] ID_EXE_ALU_B,
  input  logic [XLEN-1:0] ID_EXE_data_out,
  input  logic            ID_EXE_mem_w,
  input  logic            ID_EXE_mem_r,
  input  logic            ID_EXE_reg_write,
  input  logic [RW-1:0]   ID_EXE_written_reg,
  input  logic            EXE_MEM_reg_write,
  input  logic            EXE_MEM_mem_r,
  input  logic            EXE_MEM_mem_access,
  input  logic [RW-1:0]   EXE_MEM_written_reg,
  input  logic [XLEN-1:0] EXE_MEM_ALU_out,
  input  logic            mem_ready,
  input  logic            MEM_WB_reg_write,
  input  logic [RW-1:0]   MEM_WB_written_reg,
  input  logic [XLEN-1:0] WB_wt_data,
  output logic [XLEN-1:0] forwarding_ALU_A_out,
  output logic [XLEN-1:0] forwarding_ALU_B_out,
  output logic [XLEN-1:0] forwarding_data_out,
  output logic            stall_pc,
  output logic            stall_IF_ID,
  output logic            flush_ID_EXE,
  output logic            stall_all,
  output logic            mem_timeout
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [1:0]      state, state_nxt;
  logic [7:0]      wait_cnt, wait_cnt_nxt;
  logic            stall_mem;

  logic            hold_valid;
  logic [RW-1:0]   hold_reg;
  logic [XLEN-1:0] hold_data;

  // ---------------------------------------------------------------
  // Forwarding. Forwarding is disabled during reset so that the
  // outputs pass straight through, even if the hold buffer has not
  // been cleared yet.
  // ---------------------------------------------------------------
  logic            fwd_en;
  logic            exe_src_ok, wb_src_ok, hold_src_ok;
  logic            a_exe, a_wb, a_hold;
  logic            b_exe, b_wb, b_hold;
  logic [XLEN-1:0] fwd_a, fwd_r2;

  assign fwd_en      = !rst;
  // A load in EXE_MEM has no data yet; its ALU_out is only the address.
  assign exe_src_ok  = fwd_en && EXE_MEM_reg_write && !EXE_MEM_mem_r && (EXE_MEM_written_reg != '0);
  assign wb_src_ok   = fwd_en && MEM_WB_reg_write && (MEM_WB_written_reg != '0);
  assign hold_src_ok = fwd_en && hold_valid && (hold_reg != '0);

  assign a_exe  = exe_src_ok  && (EXE_MEM_written_reg == ID_EXE_read_reg1);
  assign a_wb   = wb_src_ok   && (MEM_WB_written_reg  == ID_EXE_read_reg1);
  assign a_hold = hold_src_ok && (hold_reg            == ID_EXE_read_reg1);
  assign b_exe  = exe_src_ok  && (EXE_MEM_written_reg == ID_EXE_read_reg2);
  assign b_wb   = wb_src_ok   && (MEM_WB_written_reg  == ID_EXE_read_reg2);
  assign b_hold = hold_src_ok && (hold_reg            == ID_EXE_read_reg2);

  always_comb begin
    fwd_a = ID_EXE_ALU_A;
    if (a_exe)       fwd_a = EXE_MEM_ALU_out;
    else if (a_wb)   fwd_a = WB_wt_data;
    else if (a_hold) fwd_a = hold_data;
  end

  // The rs2 result goes to the store-data path for stores, to ALU B otherwise.
  always_comb begin
    fwd_r2 = ID_EXE_mem_w ? ID_EXE_data_out : ID_EXE_ALU_B;
    if (b_exe)       fwd_r2 = EXE_MEM_ALU_out;
    else if (b_wb)   fwd_r2 = WB_wt_data;
    else if (b_hold) fwd_r2 = hold_data;
  end

  assign forwarding_ALU_A_out = fwd_a;
  assign forwarding_ALU_B_out = ID_EXE_mem_w ? ID_EXE_ALU_B : fwd_r2;
  assign forwarding_data_out  = ID_EXE_mem_w ? fwd_r2 : ID_EXE_data_out;

  // ---------------------------------------------------------------
  // Memory-wait control FSM
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_mem    = 1'b0;
    case (state)
      ST_RUN: begin
        if (EXE_MEM_mem_access && !mem_ready) begin
          stall_mem    = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          wait_cnt_nxt = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        stall_mem = !mem_ready;
        if (mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_nxt = ST_ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_ERROR: begin
        stall_mem = 1'b1;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ST_ERROR) mem_timeout <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Pipeline control. The load-use bubble is suppressed while frozen;
  // the hazard inputs are held during the freeze, so the bubble is
  // raised on the first unfrozen cycle.
  // ---------------------------------------------------------------
  logic load_use, bubble;

  assign stall_all = !rst && stall_mem;
  assign load_use  = ID_EXE_mem_r && ID_EXE_reg_write && (ID_EXE_written_reg != '0) &&
                     ((ID_EXE_written_reg == IF_ID_rs1) || (ID_EXE_written_reg == IF_ID_rs2));
  assign bubble    = !rst && !stall_all && load_use;

  assign stall_pc     = stall_all || bubble;
  assign stall_IF_ID  = stall_all || bubble;
  assign flush_ID_EXE = bubble;

  // ---------------------------------------------------------------
  // Hold buffer: while frozen, MEM_WB still retires, and its result
  // would otherwise be lost before the consumer in execute advances.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_reg   <= '0;
      hold_data  <= '0;
    end else if (!stall_all) begin
      hold_valid <= 1'b0;
    end else if (MEM_WB_reg_write && (MEM_WB_written_reg != '0)) begin
      hold_valid <= 1'b1;
      hold_reg   <= MEM_WB_written_reg;
      hold_data  <= WB_wt_data;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [RW-1:0]   IF_ID_rs1, IF_ID_rs2;
  logic [RW-1:0]   ID_EXE_read_reg1, ID_EXE_read_reg2;
  logic [XLEN-1:0] ID_EXE_ALU_A, ID_EXE_ALU_B, ID_EXE_data_out;
  logic            ID_EXE_mem_w, ID_EXE_mem_r, ID_EXE_reg_write;
  logic [RW-1:0]   ID_EXE_written_reg;
  logic            EXE_MEM_reg_write, EXE_MEM_mem_r, EXE_MEM_mem_access;
  logic [RW-1:0]   EXE_MEM_written_reg;
  logic [XLEN-1:0] EXE_MEM_ALU_out;
  logic            mem_ready;
  logic            MEM_WB_reg_write;
  logic [RW-1:0]   MEM_WB_written_reg;
  logic [XLEN-1:0] WB_wt_data;
  logic [XLEN-1:0] forwarding_ALU_A_out, forwarding_ALU_B_out, forwarding_data_out;
  logic            stall_pc, stall_IF_ID, flush_ID_EXE, stall_all, mem_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .RW(RW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_EXE_read_reg1(ID_EXE_read_reg1), .ID_EXE_read_reg2(ID_EXE_read_reg2),
    .ID_EXE_ALU_A(ID_EXE_ALU_A), .ID_EXE_ALU_B(ID_EXE_ALU_B), .ID_EXE_data_out(ID_EXE_data_out),
    .ID_EXE_mem_w(ID_EXE_mem_w), .ID_EXE_mem_r(ID_EXE_mem_r), .ID_EXE_reg_write(ID_EXE_reg_write),
    .ID_EXE_written_reg(ID_EXE_written_reg),
    .EXE_MEM_reg_write(EXE_MEM_reg_write), .EXE_MEM_mem_r(EXE_MEM_mem_r),
    .EXE_MEM_mem_access(EXE_MEM_mem_access), .EXE_MEM_written_reg(EXE_MEM_written_reg),
    .EXE_MEM_ALU_out(EXE_MEM_ALU_out), .mem_ready(mem_ready),
    .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_written_reg(MEM_WB_written_reg),
    .WB_wt_data(WB_wt_data),
    .forwarding_ALU_A_out(forwarding_ALU_A_out), .forwarding_ALU_B_out(forwarding_ALU_B_out),
    .forwarding_data_out(forwarding_data_out),
    .stall_pc(stall_pc), .stall_IF_ID(stall_IF_ID), .flush_ID_EXE(flush_ID_EXE),
    .stall_all(stall_all), .mem_timeout(mem_timeout)
  );

  task automatic chk32(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input string tag, input logic sa, input logic sp, input logic fl);
    chk1({tag, ".stall_all"}, stall_all, sa);
    chk1({tag, ".stall_pc"}, stall_pc, sp);
    chk1({tag, ".stall_IF_ID"}, stall_IF_ID, sp);
    chk1({tag, ".flush_ID_EXE"}, flush_ID_EXE, fl);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IF_ID_rs1 = '0; IF_ID_rs2 = '0;
    ID_EXE_read_reg1 = '0; ID_EXE_read_reg2 = '0;
    ID_EXE_ALU_A = 32'h11; ID_EXE_ALU_B = 32'h22; ID_EXE_data_out = 32'h33;
    ID_EXE_mem_w = 1'b0; ID_EXE_mem_r = 1'b0; ID_EXE_reg_write = 1'b0;
    ID_EXE_written_reg = '0;
    EXE_MEM_reg_write = 1'b0; EXE_MEM_mem_r = 1'b0; EXE_MEM_mem_access = 1'b0;
    EXE_MEM_written_reg = '0; EXE_MEM_ALU_out = '0;
    mem_ready = 1'b0;
    MEM_WB_reg_write = 1'b0; MEM_WB_written_reg = '0; WB_wt_data = '0;
  endtask

  initial begin
    // Reset: everything that would stall or forward is masked.
    clear_inputs();
    rst = 1'b1;
    ID_EXE_mem_r = 1'b1; ID_EXE_reg_write = 1'b1; ID_EXE_written_reg = 5'd3; IF_ID_rs1 = 5'd3;
    EXE_MEM_mem_access = 1'b1;
    EXE_MEM_reg_write = 1'b1; EXE_MEM_written_reg = 5'd6; EXE_MEM_ALU_out = 32'hDEAD;
    ID_EXE_read_reg1 = 5'd6;
    step();
    #2;
    ctrl("rst", 1'b0, 1'b0, 1'b0);
    chk1("rst.mem_timeout", mem_timeout, 1'b0);
    chk32("rst.alu_a_pass", forwarding_ALU_A_out, 32'h11);
    step();
    clear_inputs();
    rst = 1'b0;
    #2;
    ctrl("idle", 1'b0, 1'b0, 1'b0);

    // EXE_MEM has priority over MEM_WB.
    EXE_MEM_reg_write = 1'b1; EXE_MEM_written_reg = 5'd5; EXE_MEM_ALU_out = 32'hAA;
    MEM_WB_reg_write = 1'b1; MEM_WB_written_reg = 5'd5; WB_wt_data = 32'hBB;
    ID_EXE_read_reg1 = 5'd5;
    #2 chk32("prio.exe_mem", forwarding_ALU_A_out, 32'hAA);
    EXE_MEM_written_reg = 5'd0;
    #2 chk32("exe_rd0.mem_wb", forwarding_ALU_A_out, 32'hBB);
    EXE_MEM_written_reg = 5'd5; EXE_MEM_mem_r = 1'b1;
    #2 chk32("exe_load.mem_wb", forwarding_ALU_A_out, 32'hBB);
    EXE_MEM_mem_r = 1'b0; EXE_MEM_written_reg = 5'd0; MEM_WB_written_reg = 5'd0;
    ID_EXE_read_reg1 = 5'd0;
    #2 chk32("x0.pass", forwarding_ALU_A_out, 32'h11);

    // Store: rs2 result goes to store data, ALU B passes through.
    step();
    clear_inputs();
    ID_EXE_mem_w = 1'b1; ID_EXE_read_reg2 = 5'd7;
    MEM_WB_reg_write = 1'b1; MEM_WB_written_reg = 5'd7; WB_wt_data = 32'h1234;
    #2;
    chk32("store.data_out", forwarding_data_out, 32'h1234);
    chk32("store.alu_b", forwarding_ALU_B_out, 32'h22);
    ID_EXE_mem_w = 1'b0;
    #2;
    chk32("alu.alu_b", forwarding_ALU_B_out, 32'h1234);
    chk32("alu.data_out", forwarding_data_out, 32'h33);

    // Load-use bubble for exactly one cycle.
    step();
    clear_inputs();
    ID_EXE_mem_r = 1'b1; ID_EXE_reg_write = 1'b1; ID_EXE_written_reg = 5'd3; IF_ID_rs2 = 5'd3;
    #2 ctrl("lu.bubble", 1'b0, 1'b1, 1'b1);
    step();
    clear_inputs();
    IF_ID_rs2 = 5'd3;
    EXE_MEM_mem_r = 1'b1; EXE_MEM_reg_write = 1'b1; EXE_MEM_written_reg = 5'd3;
    EXE_MEM_mem_access = 1'b1; mem_ready = 1'b1;
    #2 ctrl("lu.after", 1'b0, 1'b0, 1'b0);
    ID_EXE_mem_r = 1'b1; ID_EXE_reg_write = 1'b1; ID_EXE_written_reg = 5'd0;
    EXE_MEM_mem_access = 1'b0; IF_ID_rs1 = 5'd0;
    #2 ctrl("lu.x0", 1'b0, 1'b0, 1'b0);

    // Memory stall of three cycles with hold-buffer capture and a
    // load-use hazard that must surface once the stall releases.
    step();
    clear_inputs();
    EXE_MEM_mem_access = 1'b1; mem_ready = 1'b0;
    MEM_WB_reg_write = 1'b1; MEM_WB_written_reg = 5'd9; WB_wt_data = 32'h55;
    ID_EXE_read_reg1 = 5'd9;
    ID_EXE_mem_r = 1'b1; ID_EXE_reg_write = 1'b1; ID_EXE_written_reg = 5'd4; IF_ID_rs1 = 5'd4;
    #2;
    ctrl("ms.c1", 1'b1, 1'b1, 1'b0);
    chk32("ms.c1.alu_a", forwarding_ALU_A_out, 32'h55);
    step();
    MEM_WB_reg_write = 1'b0; MEM_WB_written_reg = '0; WB_wt_data = '0;
    #2;
    ctrl("ms.c2", 1'b1, 1'b1, 1'b0);
    chk32("ms.c2.alu_a", forwarding_ALU_A_out, 32'h55);
    step();
    #2;
    ctrl("ms.c3", 1'b1, 1'b1, 1'b0);
    chk32("ms.c3.alu_a", forwarding_ALU_A_out, 32'h55);
    step();
    mem_ready = 1'b1;
    #2;
    ctrl("ms.release", 1'b0, 1'b1, 1'b1);
    chk32("ms.release.alu_a", forwarding_ALU_A_out, 32'h55);
    step();
    clear_inputs();
    ID_EXE_read_reg1 = 5'd9;
    #2;
    chk32("ms.hold_cleared", forwarding_ALU_A_out, 32'h11);
    ctrl("ms.run", 1'b0, 1'b0, 1'b0);

    // Timeout: 1 RUN stall cycle, then MEM_WAIT with counts 1..4, then ERROR.
    EXE_MEM_mem_access = 1'b1; mem_ready = 1'b0;
    step();
    step();
    step();
    step();
    #2;
    chk1("to.wait4.stall", stall_all, 1'b1);
    chk1("to.wait4.flag", mem_timeout, 1'b0);
    step();
    #2;
    chk1("to.err.flag", mem_timeout, 1'b1);
    chk1("to.err.stall", stall_all, 1'b1);
    EXE_MEM_mem_access = 1'b0; mem_ready = 1'b1;
    step();
    #2;
    chk1("to.sticky.flag", mem_timeout, 1'b1);
    chk1("to.sticky.stall", stall_all, 1'b1);
    rst = 1'b1;
    #1 chk1("to.rst.stall", stall_all, 1'b0);
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk1("to.post_rst.flag", mem_timeout, 1'b0);
    ctrl("to.post_rst", 1'b0, 1'b0, 1'b0);
    step();
    #2;
    chk1("to.run.flag", mem_timeout, 1'b0);
    chk1("to.run.stall", stall_all, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
